// File: rtl/addfloat_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one pipelined AddFloat core.
// A tag pipeline follows each issued operation so its sum is routed back to its owner.
module addfloat_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [32*NUM_REQ-1:0]  i_a,
  input  logic [32*NUM_REQ-1:0]  i_b,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ-1:0]     o_busy,
  output logic [NUM_REQ-1:0]     o_done,
  output logic [31:0]            o_result,
  output logic                   o_add_ce,
  output logic [31:0]            o_add_a,
  output logic [31:0]            o_add_b,
  input  logic [31:0]            i_add_result
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [ID_W-1:0]    last_grant_reg;
  logic [ID_W-1:0]    scan_idx;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] busy_next;
  logic [31:0]        a_arr [NUM_REQ];
  logic [31:0]        b_arr [NUM_REQ];

  logic [LATENCY-1:0] tag_valid_reg;
  logic [ID_W-1:0]    tag_id_reg [LATENCY];
  logic               tail_valid;
  logic [ID_W-1:0]    tail_id;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = i_a[32*gi +: 32];
    assign b_arr[gi] = i_b[32*gi +: 32];
  end

  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = ID_W'((int'(last_grant_reg) + k) % NUM_REQ);
      if (i_req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  assign grant_any = ce & win_found;

  always_comb begin
    grant = '0;
    if (grant_any) grant[win_id] = 1'b1;
  end

  assign o_grant    = grant;
  assign o_add_ce   = ce;
  assign tail_valid = tag_valid_reg[LATENCY-1];
  assign tail_id    = tag_id_reg[LATENCY-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_valid_reg[s] <= 1'b0;
        tag_id_reg[s]    <= '0;
      end
    end else if (ce) begin
      tag_valid_reg[0] <= grant_any;
      tag_id_reg[0]    <= win_id;
      for (int s = LATENCY - 1; s > 0; s--) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

  // Per-requester in-flight count; a simultaneous issue and retire cancel out.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             retire;

    assign retire = tail_valid && (tail_id == ID_W'(gi));

    always_comb begin
      cnt_next = cnt_reg;
      if (grant[gi] && !retire)      cnt_next = cnt_reg + 1'b1;
      else if (!grant[gi] && retire) cnt_next = cnt_reg - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset)   cnt_reg <= '0;
      else if (ce) cnt_reg <= cnt_next;
    end

    assign busy_next[gi] = (cnt_next != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      o_add_a        <= '0;
      o_add_b        <= '0;
      o_result       <= '0;
      o_done         <= '0;
      o_busy         <= '0;
    end else if (ce) begin
      if (grant_any) begin
        o_add_a        <= a_arr[win_id];
        o_add_b        <= b_arr[win_id];
        last_grant_reg <= win_id;
      end
      o_busy <= busy_next;
      o_done <= '0;
      if (tail_valid) begin
        o_result        <= i_add_result;
        o_done[tail_id] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_addfloat_arbiter.sv
// Bench for addfloat_arbiter: a latency-5 adder model plus a queue-based reference
// of arbitration order and result routing, driven by directed and random traffic.
module tb_addfloat_arbiter;
  localparam int N = 4;
  localparam int L = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            ce;
  logic [N-1:0]    req;
  logic [32*N-1:0] a;
  logic [32*N-1:0] b;
  logic [N-1:0]    o_grant;
  logic [N-1:0]    o_busy;
  logic [N-1:0]    o_done;
  logic [31:0]     o_result;
  logic            o_add_ce;
  logic [31:0]     o_add_a;
  logic [31:0]     o_add_b;
  logic [31:0]     i_add_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  addfloat_arbiter #(.NUM_REQ(N), .LATENCY(L)) dut (
    .clock(clock), .reset(reset), .ce(ce), .i_req(req), .i_a(a), .i_b(b),
    .o_grant(o_grant), .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_add_ce(o_add_ce), .o_add_a(o_add_a), .o_add_b(o_add_b),
    .i_add_result(i_add_result)
  );

  always #5 clock = ~clock;

  // IEEE single add via exact double arithmetic; operands stay normal and close in range.
  function automatic real s2r(logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] d2s(logic [63:0] d);
    logic [23:0] m;
    logic [8:0]  e;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = 9'(int'(d[62:52]) - 1023 + 127);
    m = {1'b0, d[51:29]};
    if (d[28] && (d[27:0] != 28'd0 || d[29])) m = m + 24'd1;
    if (m[23]) begin
      e = e + 9'd1;
      m = '0;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] x, logic [31:0] y);
    return d2s($realtobits(s2r(x) + s2r(y)));
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
  endfunction

  // Shared adder: sum visible LATENCY enabled edges after the operand registers load.
  logic [31:0] add_pipe [L-1];
  always @(posedge clock) begin
    if (o_add_ce) begin
      add_pipe[0] <= fadd(o_add_a, o_add_b);
      for (int s = 1; s < L - 1; s++) add_pipe[s] <= add_pipe[s-1];
    end
  end
  assign i_add_result = add_pipe[L-2];

  // Reference: pending ops in issue order, each with enabled edges left until o_done.
  typedef struct {
    int          id;
    logic [31:0] sum;
    int          rem;
  } op_t;
  op_t          q[$];
  int           model_last;
  logic [N-1:0] done_exp;
  logic [31:0]  result_exp;

  function automatic logic [N-1:0] model_grant();
    if (!ce) return '0;
    for (int k = 1; k <= N; k++) begin
      int j = (model_last + k) % N;
      if (req[j]) return N'(1) << j;
    end
    return '0;
  endfunction

  function automatic logic [N-1:0] busy_model();
    logic [N-1:0] r = '0;
    foreach (q[i]) r[q[i].id] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    done_exp   = '0;
    result_exp = '0;
    model_last = N - 1;
  endtask

  task automatic tick();
    logic [N-1:0] g;
    g = model_grant();
    @(posedge clock);
    if (ce) begin
      done_exp = '0;
      foreach (q[i]) q[i].rem--;
      if (q.size() > 0 && q[0].rem == 0) begin
        done_exp[q[0].id] = 1'b1;
        result_exp = q[0].sum;
        $display("t=%0t done req=%0d result=%h", $time, q[0].id, q[0].sum);
        q.delete(0);
      end
      for (int w = 0; w < N; w++) begin
        if (g[w]) begin
          q.push_back('{id: w, sum: fadd(a[32*w +: 32], b[32*w +: 32]), rem: L});
          model_last = w;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic new_ops(int w);
    a[32*w +: 32] = rand_float();
    b[32*w +: 32] = rand_float();
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; req = '0; a = '0; b = '0;
    #2;
    checks++;
    if ({o_busy, o_done, o_result, o_add_a, o_add_b} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h a=%h b=%h, expected all zero",
               o_busy, o_done, o_result, o_add_a, o_add_b);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_contention();
    int order[$];
    int dorder[$];
    logic [N-1:0] gexp;
    bit ok;
    req = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    for (int c = 0; c < 14; c++) begin
      #1;
      gexp = model_grant();
      checks++;
      if (o_grant !== gexp) begin
        errors++; $display("FAIL contention_grant: got %b expected %b", o_grant, gexp);
      end
      for (int i = 0; i < N; i++) if (o_grant[i]) order.push_back(i);
      tick();
      req = req & ~gexp;
      checks++;
      if ({o_done, o_busy, o_result} !== {done_exp, busy_model(), result_exp}) begin
        errors++;
        $display("FAIL contention_out: got done=%b busy=%b result=%h expected done=%b busy=%b result=%h",
                 o_done, o_busy, o_result, done_exp, busy_model(), result_exp);
      end
      for (int i = 0; i < N; i++) if (o_done[i]) dorder.push_back(i);
    end
    ok = (order.size() == N) && (dorder.size() == N);
    if (ok) for (int i = 0; i < N; i++) if (order[i] != i || dorder[i] != i) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL contention_order: grants %p dones %p, expected 0,1,2,3 for both", order, dorder);
    end
  endtask

  task automatic test_single();
    int gcyc = -1;
    int dcyc = -1;
    logic [N-1:0] gexp;
    req = 4'b0001;
    a[31:0] = 32'h3F80_0000;
    b[31:0] = 32'h3FA6_6666;
    for (int c = 0; c < 10; c++) begin
      #1;
      gexp = model_grant();
      checks++;
      if (o_grant !== gexp || (c == 0 && o_grant !== 4'b0001)) begin
        errors++; $display("FAIL single_grant: got %b expected %b", o_grant, gexp);
      end
      if (o_grant[0]) gcyc = cyc;
      tick();
      req = req & ~gexp;
      if (c == 0) begin
        checks++;
        if ({o_add_a, o_add_b} !== {32'h3F80_0000, 32'h3FA6_6666}) begin
          errors++; $display("FAIL single_operands: got a=%h b=%h expected 3f800000 3fa66666", o_add_a, o_add_b);
        end
      end
      checks++;
      if ({o_done, o_busy, o_result} !== {done_exp, busy_model(), result_exp}) begin
        errors++;
        $display("FAIL single_out: got done=%b busy=%b result=%h expected done=%b busy=%b result=%h",
                 o_done, o_busy, o_result, done_exp, busy_model(), result_exp);
      end
      if (o_done[0] && dcyc < 0) begin
        dcyc = cyc;
        checks++;
        if (o_result !== 32'h4013_3333) begin
          errors++; $display("FAIL single_sum: got %h expected 40133333", o_result);
        end
      end
    end
    checks++;
    if (dcyc - gcyc != L + 1) begin
      errors++; $display("FAIL single_latency: got %0d cycles expected %0d", dcyc - gcyc, L + 1);
    end
  endtask

  task automatic test_fairness();
    int prev = -1;
    int n0 = 0;
    int n2 = 0;
    bit twice = 0;
    logic [N-1:0] gexp;
    req = 4'b0101;
    new_ops(0);
    new_ops(2);
    for (int c = 0; c < 16; c++) begin
      if (c == 8) req = '0;
      #1;
      gexp = model_grant();
      checks++;
      if (o_grant !== gexp) begin
        errors++; $display("FAIL fairness_grant: got %b expected %b", o_grant, gexp);
      end
      for (int i = 0; i < N; i++) begin
        if (o_grant[i]) begin
          if (i == prev) twice = 1;
          prev = i;
          if (i == 0) n0++;
          if (i == 2) n2++;
        end
      end
      tick();
      if (gexp[0]) new_ops(0);
      if (gexp[2]) new_ops(2);
      checks++;
      if ({o_done, o_busy, o_result} !== {done_exp, busy_model(), result_exp}) begin
        errors++;
        $display("FAIL fairness_out: got done=%b busy=%b result=%h expected done=%b busy=%b result=%h",
                 o_done, o_busy, o_result, done_exp, busy_model(), result_exp);
      end
    end
    checks++;
    if (twice || n0 != 4 || n2 != 4) begin
      errors++; $display("FAIL fairness_alternation: got n0=%0d n2=%0d repeat=%0d expected 4 4 0", n0, n2, twice);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    bit gap = 0;
    logic [N-1:0] gexp;
    req = 4'b0010;
    new_ops(1);
    for (int c = 0; c < 16; c++) begin
      if (c == 6) req = '0;
      #1;
      gexp = model_grant();
      checks++;
      if (o_grant !== gexp) begin
        errors++; $display("FAIL stream_grant: got %b expected %b", o_grant, gexp);
      end
      tick();
      if (c < 6) new_ops(1);
      checks++;
      if ({o_done, o_busy, o_result} !== {done_exp, busy_model(), result_exp}) begin
        errors++;
        $display("FAIL stream_out: got done=%b busy=%b result=%h expected done=%b busy=%b result=%h",
                 o_done, o_busy, o_result, done_exp, busy_model(), result_exp);
      end
      if (o_done[1]) ndone++;
      if (!o_busy[1] && ndone < 6) gap = 1;
    end
    checks++;
    if (ndone != 6 || gap) begin
      errors++; $display("FAIL stream_busy: got %0d pulses, busy gap=%0d expected 6 pulses, no gap", ndone, gap);
    end
  endtask

  task automatic test_ce_gap();
    int gcyc = -1;
    int dcyc = -1;
    logic [N-1:0] gexp;
    logic [3*N+95:0] snap;
    req = 4'b1100;
    new_ops(2);
    new_ops(3);
    snap = '0;
    for (int c = 0; c < 16; c++) begin
      if (c == 2) begin
        ce = 1'b0;
        req[0] = 1'b1;
        new_ops(0);
      end
      if (c == 5) ce = 1'b1;
      #1;
      if (c == 2) snap = {o_done, o_busy, o_result, o_add_a, o_add_b};
      gexp = model_grant();
      checks++;
      if (o_grant !== gexp) begin
        errors++; $display("FAIL gap_grant: got %b expected %b", o_grant, gexp);
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if ({o_done, o_busy, o_result, o_add_a, o_add_b} !== snap || (c < 5 && (o_grant !== '0 || o_add_ce !== 1'b0))) begin
          errors++;
          $display("FAIL gap_freeze: got outputs=%h grant=%b add_ce=%b expected outputs=%h, no grant while disabled",
                   {o_done, o_busy, o_result, o_add_a, o_add_b}, o_grant, o_add_ce, snap);
        end
      end
      if (o_grant[2] && gcyc < 0) gcyc = cyc;
      tick();
      req = req & ~gexp;
      checks++;
      if ({o_done, o_busy, o_result} !== {done_exp, busy_model(), result_exp}) begin
        errors++;
        $display("FAIL gap_out: got done=%b busy=%b result=%h expected done=%b busy=%b result=%h",
                 o_done, o_busy, o_result, done_exp, busy_model(), result_exp);
      end
      if (o_done[2] && dcyc < 0) dcyc = cyc;
    end
    checks++;
    if (dcyc - gcyc != L + 1 + 3) begin
      errors++; $display("FAIL gap_latency: got %0d cycles expected %0d", dcyc - gcyc, L + 4);
    end
  endtask

  task automatic test_reset_midflight();
    int n3 = 0;
    logic [N-1:0] gexp;
    req = 4'b0111;
    for (int i = 0; i < 3; i++) new_ops(i);
    for (int c = 0; c < 5; c++) begin
      #1;
      gexp = model_grant();
      checks++;
      if (o_grant !== gexp) begin
        errors++; $display("FAIL midreset_grant: got %b expected %b", o_grant, gexp);
      end
      tick();
      req = req & ~gexp;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_done, o_result, o_add_a, o_add_b} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: got busy=%b done=%b result=%h a=%h b=%h expected all zero",
               o_busy, o_done, o_result, o_add_a, o_add_b);
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    req = 4'b1000;
    new_ops(3);
    for (int c = 0; c < 12; c++) begin
      #1;
      gexp = model_grant();
      checks++;
      if (o_grant !== gexp || (c == 0 && o_grant !== 4'b1000)) begin
        errors++; $display("FAIL midreset_req3_grant: got %b expected %b", o_grant, gexp);
      end
      tick();
      req = req & ~gexp;
      checks++;
      if ({o_done, o_busy, o_result} !== {done_exp, busy_model(), result_exp}) begin
        errors++;
        $display("FAIL midreset_out: got done=%b busy=%b result=%h expected done=%b busy=%b result=%h",
                 o_done, o_busy, o_result, done_exp, busy_model(), result_exp);
      end
      if (o_done[3]) n3++;
    end
    checks++;
    if (n3 != 1) begin
      errors++; $display("FAIL midreset_req3_done: got %0d pulses expected 1", n3);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] gexp;
    for (int c = 0; c < 400; c++) begin
      ce = ($urandom_range(0, 7) != 0) || (c >= 380);
      for (int i = 0; i < N; i++) begin
        if (c >= 370) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          new_ops(i);
        end else if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
      #1;
      gexp = model_grant();
      checks++;
      if (o_grant !== gexp) begin
        errors++; $display("FAIL random_grant: cycle %0d got %b expected %b", c, o_grant, gexp);
      end
      tick();
      req = req & ~gexp;
      checks++;
      if ({o_done, o_busy, o_result} !== {done_exp, busy_model(), result_exp}) begin
        errors++;
        $display("FAIL random_out: cycle %0d got done=%b busy=%b result=%h expected done=%b busy=%b result=%h",
                 c, o_done, o_busy, o_result, done_exp, busy_model(), result_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_back_to_back();
    test_ce_gap();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/addfloat_arbiter.md
# addfloat_arbiter

Round-robin scheduler that shares one pipelined `AddFloat` core among `NUM_REQ` independent requesters. It accepts at most one operand pair per enabled cycle and drives the adder operand registers and clock enable. It tracks ownership of every in-flight operation with a tag pipeline and returns each sum to its originating requester. It sits between the generated method blocks (each formerly owning a private `AddFloat`) and a single shared `AddFloat` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `LATENCY`, 5: enabled clock edges from the edge that loads `o_add_a`/`o_add_b` to the edge at which `i_add_result` holds that sum; ≥1.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  global clock enable; when low, all state freezes.
- `i_req`  in  NUM_REQ  per-requester request level; held with operands until granted.
- `i_a`  in  32*NUM_REQ  operand A, requester i at [32i+31:32i], IEEE-754 single.
- `i_b`  in  32*NUM_REQ  operand B, same packing.
- `o_grant`  out  NUM_REQ  combinational one-hot; operands of that requester are taken at this edge.
- `o_busy`  out  NUM_REQ  registered; requester has ≥1 operation in flight.
- `o_done`  out  NUM_REQ  registered one-hot pulse: `o_result` belongs to that requester.
- `o_result`  out  32  registered sum, valid while any `o_done` bit is high.
- `o_add_ce`  out  1  adder `aclken`, equal to `ce`.
- `o_add_a`  out  32  registered adder port A.
- `o_add_b`  out  32  registered adder port B.
- `i_add_result`  in  32  adder result.

## Operation
- Arbitration is evaluated each cycle over `i_req`. The search starts at `(last_grant+1) mod NUM_REQ` and picks the first requester with its bit set. `last_grant` resets to `NUM_REQ-1`, so requester 0 wins first.
- `o_grant[w] = ce & i_req[w]` for winner w; all zeros if no request or `ce=0`.
- On an edge with a grant:
  - `o_add_a <= i_a[w]`, `o_add_b <= i_b[w]`.
  - `last_grant <= w`.
  - Tag pipeline stage 0 loads {valid=1, id=w}.
  - `cnt[w]` increments.
- On an edge without a grant: stage 0 loads valid=0. `o_add_a`/`o_add_b` hold their values.
- Tag pipeline: `LATENCY` stages, shifting on every `ce` edge. The tail (stage `LATENCY-1`) aligns with `i_add_result`.
- On an edge where the tail is valid with id k:
  - `o_result <= i_add_result`.
  - `o_done <= onehot(k)`.
  - `cnt[k]` decrements.
- Otherwise `o_done <= 0` and `o_result` holds.
- When the same requester is granted and completes on the same edge, `cnt` is unchanged.
- `cnt[i]` width is clog2(LATENCY+1); it cannot overflow because at most `LATENCY` operations are in flight.
- `o_busy[i] <= (next cnt[i] != 0)`.
- The arbiter performs no floating-point arithmetic. NaN, Inf and denormal handling is whatever `AddFloat` does.
- Results return strictly in issue order. There is no backpressure on `o_done`: requesters must sample it in the pulse cycle.

## Timing
- Throughput: one issue per enabled cycle.
- Round trip: grant in cycle c gives `o_done` high in cycle c+LATENCY+1, counting enabled cycles only.
- `ce=0`:
  - `o_grant=0` and `o_add_ce=0`.
  - Tag pipeline, counters, `last_grant`, `o_add_a`/`o_add_b`, `o_result` and `o_done` all hold. A pending `o_done` pulse therefore stretches across disabled cycles.
- Reset values (asynchronous):
  - `o_busy`, `o_done`, `o_result`, `o_add_a`, `o_add_b` = 0.
  - Tag valids = 0; `cnt` = 0; `last_grant` = `NUM_REQ-1`.
- Reset during operation: all in-flight operations are dropped and no `o_done` is produced for them. The adder's internal pipeline is not reset, but its outputs are ignored because the tags are invalid.
- A requester that deasserts `i_req` before being granted is simply skipped; nothing is latched.

## Test plan
- Single op: requester 0 requests with A=0x3F800000 (1.0), B=0x3FA66666 (1.3); adder model with `LATENCY=5`.
  - Required: `o_grant=0001` in the request cycle.
  - `o_done=0001` with `o_result=0x40133333` (2.3) exactly 6 cycles later.
  - `o_busy[0]` high for exactly those intervening cycles.
- Contention: all four requesters request in the same cycle and hold until granted.
  - Required: grants 0, 1, 2, 3 on four consecutive cycles.
  - Four consecutive `o_done` pulses in the same order, each with that requester's correct sum.
- Fairness: requesters 0 and 2 hold `i_req` continuously for 8 cycles.
  - Required: grants alternate 0, 2, 0, 2, …; neither requester is granted twice in a row.
- Streaming: requester 1 issues 6 back-to-back ops with distinct operands.
  - Required: 6 consecutive `o_done[1]` pulses in issue order.
  - `o_busy[1]` stays high continuously until the last pulse.
- `ce` gap: drop `ce` for 3 cycles with 2 ops in flight.
  - Required: no grants during the gap and all outputs frozen.
  - Results arrive 3 cycles later than nominal, with correct values.
- Reset mid-flight: assert `reset` 2 cycles after 3 grants.
  - Required: all outputs 0 immediately.
  - No `o_done` afterwards for those ops.
  - The next request from requester 3 alone is granted and completes normally.
